// File: rtl/image_pkg.sv
// image_pkg: shared widths and loader state encoding for the image loader
package image_pkg;
  localparam int MEM_DATA_W = 128;
  localparam int MEM_ADDR_W = 16;
  localparam int DEPTH_W = 17;
  localparam int PIX_PER_WORD = 16;
  typedef enum logic [1:0] {IDLE, LOAD, PULSE} loader_state_t;
endpackage

// File: rtl/image_loader_if.sv
// image_loader_if: pixel stream handshake plus input-memory write port
interface image_loader_if;
  import image_pkg::*;
  logic pix_valid;
  logic [7:0] pix_data;
  logic pix_ready;
  logic input_mem_WE;
  logic [MEM_ADDR_W-1:0] input_mem_waddr;
  logic [MEM_DATA_W-1:0] input_mem_wdata;
  modport master(output pix_valid, pix_data, input pix_ready, input_mem_WE, input_mem_waddr, input_mem_wdata);
  modport slave(input pix_valid, pix_data, output pix_ready, input_mem_WE, input_mem_waddr, input_mem_wdata);
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: shifts accepted bytes into lanes and emits a registered 128-bit word every 16 bytes
module pixel_packer
  import image_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic accept,
  input  logic [7:0] data,
  output logic word_done,
  output logic we,
  output logic [MEM_DATA_W-1:0] wdata
);
  logic [3:0] byte_cnt;
  logic [MEM_DATA_W-9:0] lanes;
  assign word_done = accept && byte_cnt == 4'(PIX_PER_WORD - 1);
  // lanes shift right so the first byte lands in bits [7:0] once the 16th byte arrives
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= '0;
      lanes <= '0;
      we <= 1'b0;
      wdata <= '0;
    end else begin
      we <= word_done;
      if (clear) byte_cnt <= '0;
      else if (accept) byte_cnt <= byte_cnt + 4'd1;
      if (accept) lanes <= {data, lanes[MEM_DATA_W-9:8]};
      if (word_done) wdata <= {data, lanes};
    end
  end
endmodule

// File: rtl/image_loader.sv
// image_loader: packs a pixel stream into input memory and pulses the core when done; IMAGE_LOADER_CHECKSUM_EN adds a checksum output
module image_loader
  import image_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic [DEPTH_W-1:0] input_mem_depth,
  image_loader_if.slave bus,
  output logic new_image_pulse,
  output logic busy
`ifdef IMAGE_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);
  loader_state_t state, state_nxt;
  logic [DEPTH_W-1:0] depth, word_cnt;
  logic [ADDR_W-1:0] waddr;
  logic [PIX_W-1:0] pix;
  logic start_acc, accept, word_done;
  assign pix = bus.pix_data;
  assign start_acc = state == IDLE && start;
  assign accept = bus.pix_valid && bus.pix_ready;
  assign bus.input_mem_waddr = waddr;
  // a zero-word image passes through LOAD with nothing to accept, keeping the pulse two cycles after start
  always_comb begin
    state_nxt = state;
    bus.pix_ready = 1'b0;
    new_image_pulse = 1'b0;
    busy = state != IDLE;
    state_nxt = state == IDLE ? (start ? LOAD : IDLE) :
                state == LOAD ? (word_cnt == depth ? PULSE : LOAD) : IDLE;
    bus.pix_ready = state == LOAD && word_cnt != depth;
    new_image_pulse = state == PULSE;
  end
  // state, latched depth and word address; word_cnt reaches depth in the final write cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      depth <= '0;
      word_cnt <= '0;
      waddr <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        depth <= input_mem_depth > DEPTH_W'(65536) ? DEPTH_W'(65536) : input_mem_depth;
        word_cnt <= '0;
      end else if (word_done) begin
        waddr <= word_cnt[ADDR_W-1:0];
        word_cnt <= word_cnt + DEPTH_W'(1);
      end
    end
  end
  pixel_packer u_packer (
    .clock(clock),
    .reset(reset),
    .clear(start_acc),
    .accept(accept),
    .data(pix),
    .word_done(word_done),
    .we(bus.input_mem_WE),
    .wdata(bus.input_mem_wdata)
  );
`ifdef IMAGE_LOADER_CHECKSUM_EN
  // running sum of accepted pixels, restarted by each accepted start
  always_ff @(posedge clock) begin
    if (reset || start_acc) checksum <= '0;
    else if (accept) checksum <= checksum + 16'(pix);
  end
`endif
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: directed self-checking bench for image_loader
module tb_image_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [16:0] depth = '0;
  logic new_image_pulse, busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cyc[$];
  logic [15:0] wr_addr[$];
  logic [127:0] wr_data[$];
  int pulse_cyc[$];
`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] pulse_sum = '0;
`endif
  image_loader_if bus();
  image_loader dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .input_mem_depth(depth),
    .bus(bus),
    .new_image_pulse(new_image_pulse),
    .busy(busy)
`ifdef IMAGE_LOADER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (bus.input_mem_WE) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.input_mem_waddr);
      wr_data.push_back(bus.input_mem_wdata);
    end
    if (new_image_pulse) begin
      pulse_cyc.push_back(cyc);
`ifdef IMAGE_LOADER_CHECKSUM_EN
      pulse_sum = checksum;
`endif
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clear_log();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    pulse_cyc.delete();
  endtask
  task automatic do_start(input logic [16:0] d, output int t0);
    @(negedge clock);
    start = 1'b1;
    depth = d;
    t0 = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic push(input int n, input int base, input int step, input bit gaps, input int budget,
                      output int sent, output int last_cyc);
    sent = 0;
    last_cyc = -1;
    for (int c = 0; c < budget && sent < n; c++) begin
      bus.pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data = 8'(base + step * sent);
      #1;
      if (bus.pix_valid && bus.pix_ready) begin
        sent++;
        last_cyc = cyc;
      end
      @(negedge clock);
    end
    bus.pix_valid = 1'b0;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, bus.pix_ready, 1'b0);
    check({tag, "_we"}, bus.input_mem_WE, 1'b0);
    check({tag, "_waddr"}, bus.input_mem_waddr, 16'h0);
    check({tag, "_wdata"}, bus.input_mem_wdata, 128'h0);
    check({tag, "_pulse"}, new_image_pulse, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask
  initial begin
    int t0, sent, lc;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("rst");
    reset = 1'b0;
    // two back-to-back words
    clear_log();
    do_start(17'd2, t0);
    check("d2_busy_t1", busy, 1'b1);
    check("d2_ready_t1", bus.pix_ready, 1'b1);
    push(32, 0, 1, 1'b0, 100, sent, lc);
    check("d2_sent", sent, 32);
    check("d2_ready_final", bus.pix_ready, 1'b0);
    @(negedge clock);
    check("d2_busy_pulse", busy, 1'b1);
    @(negedge clock);
    check("d2_busy_fall", busy, 1'b0);
    check("d2_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("d2_addr0", wr_addr[0], 16'd0);
      check("d2_data0", wr_data[0], 128'h0f0e0d0c0b0a09080706050403020100);
      check("d2_cyc0", wr_cyc[0], t0 + 17);
      check("d2_addr1", wr_addr[1], 16'd1);
      check("d2_data1", wr_data[1], 128'h1f1e1d1c1b1a19181716151413121110);
      check("d2_cyc1", wr_cyc[1], t0 + 33);
    end
    check("d2_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) check("d2_pulse_cyc", pulse_cyc[0], t0 + 34);
    // single word with gappy valid
    clear_log();
    do_start(17'd1, t0);
    push(16, 8'ha0, 1, 1'b1, 400, sent, lc);
    check("gap_sent", sent, 16);
    repeat (4) @(negedge clock);
    check("gap_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("gap_addr", wr_addr[0], 16'd0);
      check("gap_data", wr_data[0], 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0);
      check("gap_cyc", wr_cyc[0], lc + 1);
    end
    check("gap_npulse", pulse_cyc.size(), 1);
    // empty image
    clear_log();
    do_start(17'd0, t0);
    check("d0_ready", bus.pix_ready, 1'b0);
    repeat (4) @(negedge clock);
    check("d0_nwr", wr_addr.size(), 0);
    check("d0_npulse", pulse_cyc.size(), 1);
    if (pulse_cyc.size() == 1) check("d0_pulse_cyc", pulse_cyc[0], t0 + 2);
    check("d0_busy", busy, 1'b0);
    // start ignored mid-load, extra bytes refused after completion
    clear_log();
    do_start(17'd1, t0);
    push(8, 8'h30, 1, 1'b0, 50, sent, lc);
    start = 1'b1;
    depth = 17'd5;
    @(negedge clock);
    start = 1'b0;
    push(8, 8'h38, 1, 1'b0, 50, sent, lc);
    check("mid_sent", sent, 8);
    push(16, 8'h77, 1, 1'b0, 20, sent, lc);
    check("mid_extra_sent", sent, 0);
    check("mid_ready", bus.pix_ready, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("mid_addr", wr_addr[0], 16'd0);
      check("mid_data", wr_data[0], 128'h3f3e3d3c3b3a39383736353433323130);
    end
    check("mid_npulse", pulse_cyc.size(), 1);
    // reset in the middle of the fourth word
    clear_log();
    do_start(17'd4, t0);
    push(55, 0, 1, 1'b0, 200, sent, lc);
    check("rstmid_nwr", wr_addr.size(), 3);
    reset = 1'b1;
    @(negedge clock);
    #1;
    clear_log();
    check_idle_outputs("rstmid");
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("rstmid_after_nwr", wr_addr.size(), 0);
    check("rstmid_after_npulse", pulse_cyc.size(), 0);
    do_start(17'd1, t0);
    push(16, 8'h50, 1, 1'b0, 50, sent, lc);
    repeat (3) @(negedge clock);
    check("reload_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("reload_addr", wr_addr[0], 16'd0);
      check("reload_data", wr_data[0], 128'h5f5e5d5c5b5a59585756555453525150);
    end
    check("reload_npulse", pulse_cyc.size(), 1);
`ifdef IMAGE_LOADER_CHECKSUM_EN
    clear_log();
    do_start(17'd1, t0);
    push(16, 8'hff, 0, 1'b0, 50, sent, lc);
    repeat (3) @(negedge clock);
    check("csum_npulse", pulse_cyc.size(), 1);
    check("csum_value", pulse_sum, 16'h0ff0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
